// File: rtl/spi_slave.sv
// spi_slave: 8-bit MSB-first SPI slave, all four modes, with a single-entry tx holding buffer.
// SCLK/SS_N/MOSI are oversampled by clk, so sclk must run at least 8x slower than clk.
module spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       sclk,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       tx_underrun,
   output logic       frame_err
);
   typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
   state_t state, state_nx;
   logic [2:0] sclk_r, ss_r;
   logic [1:0] mosi_r;
   logic [7:0] shift_tx, shift_rx, tx_buf;
   logic [2:0] cnt;
   logic       full, pend, cpol_l, cpha_l;
   logic       lead, trail, ss_fall, act, sample, shift, reload, consume, accept;
   // ss_n stages reset low so a frame already in progress at reset release is never entered
   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk_r <= '0;
         ss_r   <= '0;
         mosi_r <= '0;
      end else begin
         sclk_r <= {sclk_r[1:0], sclk};
         ss_r   <= {ss_r[1:0], ss_n};
         mosi_r <= {mosi_r[0], mosi};
      end
   end
   always_comb begin
      lead     = (sclk_r[2] == cpol_l) && (sclk_r[1] != cpol_l);
      trail    = (sclk_r[2] != cpol_l) && (sclk_r[1] == cpol_l);
      ss_fall  = ss_r[2] && !ss_r[1];
      act      = (state == ACTIVE) && !ss_r[1];
      sample   = act && (cpha_l ? trail : lead);
      shift    = act && (cpha_l ? lead : trail);
      reload   = shift && (cnt == 3'd0) && pend;
      consume  = ((state == LOAD) || reload) && full;
      accept   = tx_valid && !full;
      state_nx = ss_r[1] ? IDLE : (state == IDLE) ? (ss_fall ? LOAD : IDLE) : ACTIVE;
   end
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         shift_tx    <= '0;
         shift_rx    <= '0;
         tx_buf      <= '0;
         rx_data     <= '0;
         cnt         <= '0;
         full        <= 1'b0;
         pend        <= 1'b0;
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= (state != IDLE) && ss_r[1] && (cnt != 3'd0);
         if (accept) tx_buf <= tx_data;
         full <= accept || (full && !consume);
         if (state == IDLE) begin
            cnt  <= '0;
            pend <= 1'b0;
            if (ss_r[1]) begin
               cpol_l <= cpol;
               cpha_l <= cpha;
            end
         end
         if (state == LOAD) begin
            shift_tx    <= full ? tx_buf : 8'h00;
            tx_underrun <= !full;
         end
         if (sample) begin
            shift_rx <= {shift_rx[6:0], mosi_r[1]};
            cnt      <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               rx_data  <= {shift_rx[6:0], mosi_r[1]};
               rx_valid <= 1'b1;
               pend     <= 1'b1;
            end
         end
         // at bit 0 a shift edge either reloads the next byte or, first in frame, does nothing
         if (shift) begin
            if (cnt != 3'd0) shift_tx <= {shift_tx[6:0], 1'b0};
            else if (reload) begin
               shift_tx    <= full ? tx_buf : 8'h00;
               tx_underrun <= !full;
               pend        <= 1'b0;
            end
         end
      end
   end
   assign miso_oe  = (state != IDLE);
   assign miso     = miso_oe && shift_tx[7];
   assign busy     = (state == ACTIVE);
   assign tx_ready = !full;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench acting as SPI master with a scoreboard of expected received bytes.
module tb_spi_slave;
   logic       clk = 1'b0, rst = 1'b0, cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err;
   logic [7:0] rx_data;
   int         checks = 0, errors = 0, rx_cnt = 0, und_cnt = 0, ferr_cnt = 0;
   logic [7:0] exp_q[$];
   spi_slave dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      logic [7:0] e;
      if (tx_underrun) und_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
         rx_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected rx_data=%h with empty scoreboard", rx_data);
         end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin
               errors++;
               $display("FAIL rx_data got %h expected %h", rx_data, e);
            end
         end
      end
   end
   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic set_mode(input int m);
      cpol = m[1];
      cpha = m[0];
      sclk = m[1];
      clks(4);
   endtask
   task automatic write_tx(input logic [7:0] d);
      int t = 0;
      while (!tx_ready && t < 50) begin
         clks(1);
         t++;
      end
      checks++;
      if (!tx_ready) begin
         errors++;
         $display("FAIL tx_ready_timeout got %b expected 1", tx_ready);
      end else begin
         tx_data  = d;
         tx_valid = 1'b1;
         clks(1);
         tx_valid = 1'b0;
      end
   endtask
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = mo[7-i];
            clks(8);
            sclk = ~cpol;
            mi = {mi[6:0], miso};
            clks(8);
            sclk = cpol;
         end else begin
            clks(8);
            sclk = ~cpol;
            mosi = mo[7-i];
            clks(8);
            sclk = cpol;
            mi = {mi[6:0], miso};
         end
      end
   endtask
   task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
      ss_n = 1'b0;
      clks(8);
      exp_q.push_back(mo);
      xfer(mo, 8, mi);
      clks(8);
      ss_n = 1'b1;
      clks(8);
   endtask
   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({tx_ready, rx_valid, busy, miso_oe, miso, tx_underrun, frame_err} !== 7'b1000000) begin
         errors++;
         $display("FAIL %s_flags got %b expected 1000000", tag,
                  {tx_ready, rx_valid, busy, miso_oe, miso, tx_underrun, frame_err});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         errors++;
         $display("FAIL %s_rx_data got %h expected 00", tag, rx_data);
      end
   endtask
   task automatic test_reset;
      rst = 1'b0;
      clks(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      clks(6);
   endtask
   task automatic test_mode0;
      logic [7:0] mi;
      int r0;
      set_mode(0);
      write_tx(8'hA5);
      r0 = rx_cnt;
      frame(8'h3C, mi);
      checks++;
      if (mi !== 8'hA5) begin errors++; $display("FAIL mode0_miso got %h expected a5", mi); end
      checks++;
      if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL mode0_rx_pulses got %0d expected 1", rx_cnt - r0); end
   endtask
   task automatic test_modes;
      logic [7:0] mi;
      int r0;
      for (int m = 1; m < 4; m++) begin
         set_mode(m);
         write_tx(8'h81);
         r0 = rx_cnt;
         frame(8'h7E, mi);
         checks++;
         if (mi !== 8'h81) begin errors++; $display("FAIL mode%0d_miso got %h expected 81", m, mi); end
         checks++;
         if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL mode%0d_rx_pulses got %0d expected 1", m, rx_cnt - r0); end
      end
   endtask
   task automatic test_back_to_back;
      logic [7:0] m1, m2;
      int r0;
      set_mode(0);
      write_tx(8'h11);
      r0 = rx_cnt;
      ss_n = 1'b0;
      clks(8);
      write_tx(8'h22);
      exp_q.push_back(8'hC3);
      xfer(8'hC3, 8, m1);
      exp_q.push_back(8'h5A);
      xfer(8'h5A, 8, m2);
      clks(8);
      ss_n = 1'b1;
      clks(8);
      checks++;
      if (m1 !== 8'h11) begin errors++; $display("FAIL b2b_miso1 got %h expected 11", m1); end
      checks++;
      if (m2 !== 8'h22) begin errors++; $display("FAIL b2b_miso2 got %h expected 22", m2); end
      checks++;
      if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d expected 2", rx_cnt - r0); end
   endtask
   task automatic test_underrun;
      logic [7:0] mi;
      int u0;
      set_mode(1);
      u0 = und_cnt;
      frame(8'h96, mi);
      checks++;
      if (mi !== 8'h00) begin errors++; $display("FAIL underrun_miso got %h expected 00", mi); end
      checks++;
      if (und_cnt - u0 !== 1) begin errors++; $display("FAIL underrun_pulses got %0d expected 1", und_cnt - u0); end
   endtask
   task automatic test_frame_err;
      logic [7:0] mi, held;
      int r0, f0;
      set_mode(0);
      held = rx_data;
      r0 = rx_cnt;
      f0 = ferr_cnt;
      ss_n = 1'b0;
      clks(8);
      xfer(8'hF0, 5, mi);
      clks(8);
      ss_n = 1'b1;
      clks(8);
      checks++;
      if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d expected 1", ferr_cnt - f0); end
      checks++;
      if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL ferr_rx_pulses got %0d expected 0", rx_cnt - r0); end
      checks++;
      if (rx_data !== held) begin errors++; $display("FAIL ferr_rx_held got %h expected %h", rx_data, held); end
      write_tx(8'h69);
      frame(8'h3A, mi);
      checks++;
      if (mi !== 8'h69) begin errors++; $display("FAIL ferr_next_miso got %h expected 69", mi); end
      checks++;
      if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_next_pulses got %0d expected 1", ferr_cnt - f0); end
   endtask
   task automatic test_rst_mid;
      logic [7:0] mi;
      int r0, f0;
      set_mode(0);
      write_tx(8'h3C);
      r0 = rx_cnt;
      f0 = ferr_cnt;
      ss_n = 1'b0;
      clks(8);
      xfer(8'hAA, 3, mi);
      rst = 1'b0;
      clks(1);
      check_reset_outputs("midrst");
      rst = 1'b1;
      clks(8);
      ss_n = 1'b1;
      clks(8);
      checks++;
      if (rx_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL midrst_pulses got rx=%0d ferr=%0d expected 0 0", rx_cnt - r0, ferr_cnt - f0);
      end
      write_tx(8'hE7);
      frame(8'h18, mi);
      checks++;
      if (mi !== 8'hE7) begin errors++; $display("FAIL midrst_next_miso got %h expected e7", mi); end
   endtask
   initial begin
      test_reset;
      test_mode0;
      test_modes;
      test_back_to_back;
      test_underrun;
      test_frame_err;
      test_rst_mid;
      clks(4);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameters: none; frame width fixed at 8 bits, MSB first.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 cpol  input  1  SCLK idle level; sampled only while ss_n synchronized high.
REQ-005 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled like cpol.
REQ-006 sclk  input  1  serial clock from master, asynchronous to clk.
REQ-007 ss_n  input  1  slave select, active-low, asynchronous.
REQ-008 mosi  input  1  serial data from master, asynchronous.
REQ-009 miso  output  1  serial data to master; valid only when miso_oe=1.
REQ-010 miso_oe  output  1  output enable for external tri-state; 1 while selected.
REQ-011 tx_data  input  8  byte to send in next frame.
REQ-012 tx_valid  input  1  tx_data valid; transfer on tx_valid & tx_ready.
REQ-013 tx_ready  output  1  tx holding buffer empty.
REQ-014 rx_data  output  8  last complete received byte; held until next completion.
REQ-015 rx_valid  output  1  one-cycle pulse, rx_data updated this cycle.
REQ-016 busy  output  1  1 while in ACTIVE state.
REQ-017 tx_underrun  output  1  one-cycle pulse: frame started with empty tx buffer.
REQ-018 frame_err  output  1  one-cycle pulse: ss_n deasserted mid-byte.

Function
REQ-019 sclk, ss_n, mosi SHALL each pass a 2-FF synchronizer; edge detection uses a third registered stage; sclk period SHALL be >= 8 clk cycles.
REQ-020 Leading edge = synchronized sclk leaving cpol level; trailing edge = returning to cpol level.
REQ-021 States: IDLE (ss_n high), LOAD (one cycle after ss_n falling), ACTIVE; ss_n rising from any state -> IDLE next cycle.
REQ-022 IDLE: latch cpol/cpha each cycle; bit counter=0; miso_oe=0; busy=0.
REQ-023 LOAD: shift_tx <= tx buffer and buffer marked empty if full; else shift_tx <= 8'h00 and tx_underrun pulses; -> ACTIVE.
REQ-024 miso SHALL equal shift_tx[7] whenever miso_oe=1; miso_oe=1 in LOAD and ACTIVE.
REQ-025 Sample edge: shift_rx <= {shift_rx[6:0], mosi_sync}; bit counter +1 (3-bit, wraps 7->0).
REQ-026 Shift edge (opposite of sample edge): shift_tx <= {shift_tx[6:0],1'b0}; for cpha=1 the first leading edge of a byte SHALL NOT shift.
REQ-027 On 8th sample edge: rx_data <= completed byte, rx_valid pulses in the cycle rx_data changes; shift_tx reloads from buffer (or 0x00 with tx_underrun) at the following shift edge (cpha=0) or next leading edge (cpha=1), enabling back-to-back bytes under one ss_n.
REQ-028 tx_ready = buffer empty; load via handshake in the same cycle as a LOAD/reload empties it SHALL be accepted and retained.
REQ-029 ss_n rising with bit counter != 0: partial byte discarded, rx_data unchanged, no rx_valid, frame_err pulses one cycle.
REQ-030 sclk edges while ss_n synchronized high SHALL be ignored.

Reset
REQ-031 On rst=0 at clk edge: state IDLE, bit counter 0, shift regs 0, tx buffer empty, rx_data 8'h00, rx_valid 0, tx_ready 1, busy 0, miso_oe 0, miso 0, tx_underrun 0, frame_err 0.
REQ-032 Reset mid-frame SHALL abort the frame with no rx_valid or frame_err; after reset release the block waits for ss_n high before accepting a new frame.

Verification
REQ-033 Mode 0, tx=0xA5 preloaded, master sends 0x3C -> master reads 0xA5, rx_data=0x3C with single rx_valid pulse.
REQ-034 Modes 1,2,3 each, tx=0x81, master sends 0x7E -> master reads 0x81, rx_data=0x7E.
REQ-035 Two bytes under one ss_n, tx 0x11 then 0x22 written between bytes -> master reads 0x11,0x22; two rx_valid pulses.
REQ-036 Frame with no tx written -> master reads 0x00, tx_underrun one pulse.
REQ-037 ss_n raised after 5 bits -> frame_err one pulse, rx_data unchanged, no rx_valid, next full frame correct.
REQ-038 rst asserted after 3 bits -> all outputs at REQ-031 values next cycle; subsequent frame received correctly.
